a2d_spi_resp: RTL and testbench
===============================

Name: a2d_spi_resp

Overview:
- SPI responder (slave) for the A2D serial link; the far end of the A2D SPI master interface.
- Emulates an ADC128S-style 8-channel converter: each 16-bit frame carries a channel address on MOSI and returns on MISO the 12-bit result for the channel addressed in the previous frame.
- Sits in the MazeRunner sensor/testbench environment and in FPGA loopback builds.
- Sample values come from the parent through a channel-select/data lookup port.

Parameters:
- RST_CHNNL, 3'd0, channel whose result is returned in the first frame after reset.
- PAD, 4'h0, value of the upper 4 bits of every response word.

Ports:
- clk  input  1  system clock (50MHz)
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  active-low slave select from master
- SCLK  input  1  SPI clock from master, idles high
- MOSI  input  1  serial command from master, MSB first
- MISO  output  1  serial response to master, MSB first
- rd_chnnl  output  3  channel whose result is being fetched
- rd_data  input  12  parent-supplied result for rd_chnnl, combinational lookup
- cmd  output  16  last complete command word received
- cmd_vld  output  1  one-clk pulse when a full 16-bit frame completes

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low, on rst_n.
- Protocol (SPI mode 3):
  - SCLK idles high.
  - Both sides change data on SCLK fall and sample on SCLK rise.
  - 16 bits per frame, MSB first.
  - Command word = {2'b00, chnnl[2:0], 11'h000}.
- Input synchronisation:
  - SS_n, SCLK and MOSI each pass through two flops into clk, plus a third flop for edge detect.
  - SCLK period ≥ 8 clk is required; SPI_mnrch provides 32.
- Reset values:
  - MISO = 0, cmd = 16'h0000, cmd_vld = 0, rd_chnnl = RST_CHNNL.
  - Internal state = IDLE, shift registers 0, bit counter 0.
- FSM states:
  - IDLE
    - On synced SS_n fall: load tx shift register with {PAD, rd_data}, using the current rd_chnnl.
    - Clear the bit counter and go to SHIFT.
  - SHIFT
    - Synced SCLK rise: shift synced MOSI into rx_shft[0]; bit_cnt++.
    - Synced SCLK fall: shift tx register left, filling with 0. Ignore this fall if bit_cnt == 0, i.e. the first fall after SS_n fall with no preceding rise.
    - When bit_cnt reaches 16: go to DONE.
    - Synced SS_n rise with bit_cnt < 16: aborted frame. Go to IDLE; cmd, cmd_vld and rd_chnnl are unchanged.
  - DONE
    - Further SCLK edges are ignored; bit_cnt saturates at 16 and MISO holds its value.
    - On synced SS_n rise: cmd <= rx_shft, cmd_vld pulses for 1 clk, rd_chnnl <= rx_shft[13:11], then go to IDLE.
- MISO:
  - Equals tx_shft[15] while SS_n is synced low; 0 otherwise.
  - Updates within 3 clk of SCLK fall.
- Pipelining: the response in frame N equals rd_data for the channel addressed in frame N-1. A2D_intf issues CMD then RSP frames, so its second frame returns the addressed channel.
- Simultaneous events:
  - SS_n rise in the same cycle as the 16th rise: treated as a completed frame (the count includes that rise).
  - SS_n fall while in DONE without an intervening rise: cannot occur legally. If it does, treat it as a rise followed by a new frame start.
- Reset mid-frame: everything returns to reset values; the next frame starts cleanly.

Optional Feature:
- Macro: A2D_NOISE_EN.
  - Defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances once per completed frame. Its bits [1:0] are XORed into the response LSBs, i.e. tx load = {PAD, rd_data ^ {10'h0, lfsr[1:0]}}.
  - Undefined: the response is exactly {PAD, rd_data} and no LFSR logic exists.

Decomposition:
- Package a2d_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - Constants: FRAME_BITS = 16, CHNL_MSB = 13, CHNL_LSB = 11, RES_W = 12.
  - LFSR seed and taps.
- Sub-module spi_sync_edge: 3-flop synchroniser per input, producing level, rise and fall outputs. Instantiated for SS_n, SCLK and MOSI (MOSI uses the level output only).

Test Plan:
- Reset, then one frame with cmd 16'h1800 (chnnl 3), rd_data = 12'hABC, RST_CHNNL = 0 -> MISO returns 16'h0ABC (rd_data sampled with rd_chnnl = 0); afterwards rd_chnnl = 3, cmd = 16'h1800, cmd_vld pulses exactly once.
- A2D_intf driven end to end with chnnl = 5, parent mapping chnnl 5 -> 12'h5A5 -> res = 12'h5A5 and cnv_cmplt asserted.
- Back-to-back frames addressing 1, 6, 2 with lookup data = chnnl*12'h111 -> responses 0x000 (reset channel 0), 0x111, 0x666.
- SS_n raised after 9 SCLK rises during cmd 16'h3800 -> cmd_vld never pulses, rd_chnnl unchanged, next full frame behaves normally.
- Assert rst_n low mid-frame after 7 bits -> MISO = 0, rd_chnnl = RST_CHNNL immediately; next frame returns the RST_CHNNL value.
- With A2D_NOISE_EN defined, 4 frames with rd_data = 12'h800 -> response LSBs follow the LFSR sequence from seed 8'hA5 (first frame XOR 2'b01). Without the macro, all four responses are 16'h0800.

Source files
------------

// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and constants for the A2D SPI responder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CHNL_MSB   = 13;
  localparam int CHNL_LSB   = 11;
  localparam int RES_W      = 12;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting left; the taps mask
  // selects state bits 7,5,4,3 whose XOR becomes the new LSB.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI link plus parent lookup/command port bundle for the A2D responder.
// Latency: n/a (wires only).
// Backpressure: none; SPI is master-paced, cmd_vld is a bare pulse.
// Signals: SS_n/SCLK/MOSI (master->slave), MISO (slave->master),
//          rd_chnnl (slave->parent), rd_data (parent->slave, combinational),
//          cmd/cmd_vld (slave->parent).
interface a2d_spi_resp_if;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [2:0]  rd_chnnl;
  logic [11:0] rd_data;
  logic [15:0] cmd;
  logic        cmd_vld;

  modport slave (
    input  SS_n, SCLK, MOSI, rd_data,
    output MISO, rd_chnnl, cmd, cmd_vld
  );

  modport master (
    output SS_n, SCLK, MOSI, rd_data,
    input  MISO, rd_chnnl, cmd, cmd_vld
  );
endinterface

// File: rtl/a2d_spi_resp_sync.sv
// Three-flop synchroniser with level and edge outputs for one async input.
// Latency: level 2 clk, rise/fall pulse 2 clk after the input transition.
// Backpressure: none.
// Ports: clk, rst_n, i_async (raw input), o_lvl (synced level),
//        o_rise/o_fall (one-clk edge pulses). RST_VAL is the idle level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  // Reset to the idle level so that leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_lvl  = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI mode-3 responder emulating an 8-channel ADC128S-style converter.
// Latency: MISO follows SCLK fall within 3 clk; cmd/cmd_vld 2-3 clk after SS_n rise.
// Backpressure: none; the master paces the link, cmd_vld is a one-clk pulse.
// Ports: clk, rst_n (async active-low), bus (a2d_spi_resp_if.slave).
// Parameters: RST_CHNNL (channel answered in first frame after reset),
//             PAD (upper 4 bits of each response).
// Optional: define A2D_NOISE_EN to XOR an 8-bit LFSR's [1:0] into response LSBs.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter logic [2:0] RST_CHNNL = 3'd0,
  parameter logic [3:0] PAD       = 4'h0
) (
  input  logic           clk,
  input  logic           rst_n,
  a2d_spi_resp_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;
  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

  // Synchronised inputs
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_unused_sclk_lvl;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .i_async(bus.SS_n),
    .o_lvl(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(bus.SCLK),
    .o_lvl(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(bus.MOSI),
    .o_lvl(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  assign w_unused_sclk_lvl = w_sclk_lvl;

  // State
  logic [1:0]       r_state;
  logic [4:0]       r_bit_cnt;
  logic [15:0]      r_rx_shft;
  logic [15:0]      r_tx_shft;
  logic [15:0]      r_cmd;
  logic             r_cmd_vld;
  logic [2:0]       r_rd_chnnl;
  logic             r_restart;

  logic [15:0]      w_rx_nxt;
  logic [4:0]       w_cnt_nxt;
  logic             w_full;
  logic             w_frame_done;
  logic             w_start;
  logic [15:0]      w_tx_load;

  // Receive path: sample on synced SCLK rise while shifting.
  always_comb begin
    w_rx_nxt  = r_rx_shft;
    w_cnt_nxt = r_bit_cnt;
    if (r_state == ST_SHIFT && w_sclk_rise) begin
      w_rx_nxt  = {r_rx_shft[14:0], w_mosi};
      w_cnt_nxt = r_bit_cnt + 5'd1;
    end
  end

  assign w_full = (w_cnt_nxt == FULL_CNT);

  // A frame completes on SS_n rise once 16 bits are in (including a rise
  // landing in the same cycle), or on an illegal SS_n fall while in DONE,
  // which is treated as an implied rise followed by a fresh frame.
  assign w_frame_done = ((r_state == ST_SHIFT) && w_ss_rise && w_full) ||
                        ((r_state == ST_DONE)  && (w_ss_rise || w_ss_fall));

  // r_restart delays the implied frame start by one clk so the tx load sees
  // rd_data for the channel just captured.
  assign w_start = (r_state == ST_IDLE) && (w_ss_fall || r_restart);

`ifdef A2D_NOISE_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_frame_done) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign w_tx_load = {PAD, bus.rd_data ^ {10'h000, r_lfsr[1:0]}};
`else
  assign w_tx_load = {PAD, bus.rd_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 5'd0;
      r_rx_shft  <= 16'h0000;
      r_tx_shft  <= 16'h0000;
      r_cmd      <= 16'h0000;
      r_cmd_vld  <= 1'b0;
      r_rd_chnnl <= RST_CHNNL;
      r_restart  <= 1'b0;
    end else begin
      r_cmd_vld <= 1'b0;
      r_restart <= 1'b0;

      if (w_frame_done) begin
        r_cmd      <= w_rx_nxt;
        r_cmd_vld  <= 1'b1;
        r_rd_chnnl <= w_rx_nxt[CHNL_MSB:CHNL_LSB];
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_tx_shft <= w_tx_load;
            r_rx_shft <= 16'h0000;
            r_bit_cnt <= 5'd0;
            r_state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_rx_shft <= w_rx_nxt;
          r_bit_cnt <= w_cnt_nxt;
          // The first fall precedes any rise and must not disturb the MSB.
          if (w_sclk_fall && r_bit_cnt != 5'd0) begin
            r_tx_shft <= {r_tx_shft[14:0], 1'b0};
          end
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
          end else if (w_full) begin
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
          end else if (w_ss_fall) begin
            r_state   <= ST_IDLE;
            r_restart <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MISO     = ~w_ss_lvl & r_tx_shft[15];
  assign bus.cmd      = r_cmd;
  assign bus.cmd_vld  = r_cmd_vld;
  assign bus.rd_chnnl = r_rd_chnnl;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed and randomized frames against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_a2d_spi_resp;

  localparam logic [2:0] RST_CH = 3'd0;
  localparam logic [3:0] PADV   = 4'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  a2d_spi_resp_if sif ();

  a2d_spi_resp #(.RST_CHNNL(RST_CH), .PAD(PADV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(sif)
  );

  always #10 clk = ~clk;

  // Parent lookup table
  logic [11:0] tbl [8];
  always_comb sif.rd_data = tbl[sif.rd_chnnl];

  int vld_cnt = 0;
  always @(negedge clk) if (sif.cmd_vld === 1'b1) vld_cnt++;

  int errors = 0;
  int checks = 0;

  // Reference model state: channel answered next, last command, noise LFSR.
  logic [2:0]  m_prev;
  logic [15:0] m_cmd;
  logic [7:0]  m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] model_resp();
    logic [11:0] d;
    d = tbl[m_prev];
`ifdef A2D_NOISE_EN
    d = d ^ {10'h000, m_lfsr[1:0]};
`endif
    return {PADV, d};
  endfunction

  // Polynomial x^8+x^6+x^5+x^4+1 written out bit by bit.
  function automatic logic [7:0] model_lfsr_adv(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic void model_reset();
    m_prev = RST_CH;
    m_cmd  = 16'h0000;
    m_lfsr = 8'hA5;
  endfunction

  // Mode-3 master: 32-clk SCLK period, MOSI changes on fall, MISO sampled before rise.
  task automatic spi_xfer(input logic [15:0] mosi_w, input int nbits,
                          input bit raise_ss, output logic [15:0] miso_w);
    miso_w = 16'h0000;
    sif.SS_n = 1'b0;
    clk_wait(8);
    for (int i = 0; i < nbits; i++) begin
      sif.SCLK = 1'b0;
      sif.MOSI = mosi_w[15 - i];
      clk_wait(16);
      miso_w = {miso_w[14:0], sif.MISO};
      sif.SCLK = 1'b1;
      clk_wait(16);
    end
    if (raise_ss) begin
      clk_wait(4);
      sif.SS_n = 1'b1;
      clk_wait(8);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sif.SS_n = 1'b1;
    sif.SCLK = 1'b1;
    sif.MOSI = 1'b0;
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(3);
    model_reset();
  endtask

  task automatic frame(input string tag, input logic [2:0] ch);
    logic [15:0] w, r, e;
    int v0;
    w  = {2'b00, ch, 11'h000};
    e  = model_resp();
    v0 = vld_cnt;
    spi_xfer(w, 16, 1'b1, r);
    chk({tag, "_resp"}, r, e);
    chk({tag, "_cmd"}, sif.cmd, w);
    chk({tag, "_vld"}, vld_cnt - v0, 1);
    chk({tag, "_chnl"}, sif.rd_chnnl, ch);
    m_prev = ch;
    m_cmd  = w;
    m_lfsr = model_lfsr_adv(m_lfsr);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    int v0;
    for (int i = 0; i < 8; i++) tbl[i] = 12'h000;

    // Reset state
    sif.SS_n = 1'b1; sif.SCLK = 1'b1; sif.MOSI = 1'b0;
    model_reset();
    clk_wait(3);
    chk("rst_miso", sif.MISO, 0);
    chk("rst_cmd", sif.cmd, 16'h0000);
    chk("rst_vld", sif.cmd_vld, 0);
    chk("rst_chnl", sif.rd_chnnl, RST_CH);
    rst_n = 1'b1;
    clk_wait(3);

    // First frame answers the reset channel
    tbl[0] = 12'hABC;
    frame("f1800", 3'd3);

    // CMD then RSP for channel 5
    tbl[5] = 12'h5A5;
    frame("cmd5", 3'd5);
    frame("rsp5", 3'd5);

    // Back-to-back 1, 6, 2 from reset with data = chnnl*0x111
    do_reset();
    for (int i = 0; i < 8; i++) tbl[i] = 12'(i * 12'h111);
    frame("b2b1", 3'd1);
    frame("b2b6", 3'd6);
    frame("b2b2", 3'd2);

    // Aborted frame after 9 rises
    v0 = vld_cnt;
    spi_xfer(16'h3800, 9, 1'b1, r);
    chk("abort_vld", vld_cnt - v0, 0);
    chk("abort_chnl", sif.rd_chnnl, m_prev);
    chk("abort_cmd", sif.cmd, m_cmd);
    frame("post_abort", 3'd4);

    // Randomized channels and lookup data
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) tbl[i] = 12'($urandom);
      frame("rand", 3'($urandom_range(7, 0)));
    end

    // Reset mid-frame after 7 bits
    frame("pre_mid", 3'd6);
    spi_xfer(16'h2800, 7, 1'b0, r);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", sif.MISO, 0);
    chk("midrst_chnl", sif.rd_chnnl, RST_CH);
    chk("midrst_cmd", sif.cmd, 16'h0000);
    clk_wait(2);
    sif.SS_n = 1'b1; sif.SCLK = 1'b1; sif.MOSI = 1'b0;
    clk_wait(2);
    rst_n = 1'b1;
    clk_wait(3);
    model_reset();
    frame("after_mid", 3'd2);

    // Constant data: noise build shows LFSR LSBs, plain build 0x0800
    do_reset();
    for (int i = 0; i < 8; i++) tbl[i] = 12'h800;
    for (int k = 0; k < 4; k++) frame("noise", 3'($urandom_range(7, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
